// File: rtl/neopixel_bus_arbiter.sv
// Round-robin arbiter that shares the neopixel pixel-RAM control port between the
// PS register bridge (rq0) and the pattern generator (rq1), one transaction per grant.
module neopixel_bus_arbiter #(
  parameter int unsigned C_PIXELS       = 12,
  parameter int unsigned C_READ_LATENCY = 1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        rq0_req,
  input  logic        rq0_write_readf,
  input  logic [31:0] rq0_address,
  input  logic [31:0] rq0_write_data,
  output logic        rq0_ack,
  output logic        rq0_err,
  output logic [31:0] rq0_read_data,
  input  logic        rq1_req,
  input  logic        rq1_write_readf,
  input  logic [31:0] rq1_address,
  input  logic [31:0] rq1_write_data,
  output logic        rq1_ack,
  output logic        rq1_err,
  output logic [31:0] rq1_read_data,
  output logic        clock_ctrl,
  output logic        reset_ctrl,
  output logic        write_readf,
  output logic [31:0] address,
  output logic [31:0] write_data,
  input  logic [31:0] read_data,
  output logic        busy
);

  localparam int unsigned CNT_W = (C_READ_LATENCY > 2) ? $clog2(C_READ_LATENCY - 1) : 1;
  localparam logic [CNT_W-1:0] WAIT_INIT =
    CNT_W'((C_READ_LATENCY > 1) ? C_READ_LATENCY - 2 : 0);
  localparam logic [31:0] PIX_LIMIT = 32'(C_PIXELS);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_ACK   = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic             last_grant_q, last_grant_d;
  logic             grant_q, grant_d;
  logic             txn_write_q, txn_write_d;
  logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic             ack0_q, ack0_d;
  logic             ack1_q, ack1_d;
  logic             err0_q, err0_d;
  logic             err1_q, err1_d;
  logic [31:0]      rdata0_q, rdata0_d;
  logic [31:0]      rdata1_q, rdata1_d;
  logic             write_readf_q, write_readf_d;
  logic [31:0]      address_q, address_d;
  logic [31:0]      write_data_q, write_data_d;
  logic             busy_q, busy_d;

  logic             pick;
  logic             sel_write;
  logic [31:0]      sel_address;
  logic [31:0]      sel_wdata;
  logic             finish;
  logic             finish_err;
  logic [31:0]      finish_rdata;

  always_comb begin
    // On a tie the requester that did not win last time gets the port.
    pick        = (rq0_req && rq1_req) ? ~last_grant_q : rq1_req;
    sel_write   = pick ? rq1_write_readf : rq0_write_readf;
    sel_address = pick ? rq1_address     : rq0_address;
    sel_wdata   = pick ? rq1_write_data  : rq0_write_data;

    state_d       = state_q;
    last_grant_d  = last_grant_q;
    grant_d       = grant_q;
    txn_write_d   = txn_write_q;
    wait_cnt_d    = wait_cnt_q;
    write_readf_d = 1'b0;
    address_d     = address_q;
    write_data_d  = write_data_q;
    finish        = 1'b0;
    finish_err    = 1'b0;
    finish_rdata  = '0;

    unique case (state_q)
      S_IDLE: begin
        if (rq0_req || rq1_req) begin
          grant_d      = pick;
          last_grant_d = pick;
          txn_write_d  = sel_write;
          address_d    = sel_address;
          write_data_d = sel_wdata;
          if (sel_address >= PIX_LIMIT) begin
            state_d    = S_ACK;
            finish     = 1'b1;
            finish_err = 1'b1;
          end else begin
            state_d       = S_ISSUE;
            write_readf_d = sel_write;
          end
        end
      end
      S_ISSUE: begin
        if (txn_write_q) begin
          state_d = S_ACK;
          finish  = 1'b1;
        end else if (C_READ_LATENCY <= 1) begin
          state_d      = S_ACK;
          finish       = 1'b1;
          finish_rdata = read_data;
        end else begin
          state_d    = S_WAIT;
          wait_cnt_d = WAIT_INIT;
        end
      end
      S_WAIT: begin
        if (wait_cnt_q == '0) begin
          state_d      = S_ACK;
          finish       = 1'b1;
          finish_rdata = read_data;
        end else begin
          wait_cnt_d = wait_cnt_q - CNT_W'(1);
        end
      end
      S_ACK: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Completion is steered to the grantee only; the other side sees all zeros.
    ack0_d   = finish & ~grant_d;
    ack1_d   = finish &  grant_d;
    err0_d   = finish_err & ~grant_d;
    err1_d   = finish_err &  grant_d;
    rdata0_d = grant_d ? '0 : finish_rdata;
    rdata1_d = grant_d ? finish_rdata : '0;
    busy_d   = (state_d != S_IDLE);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= S_IDLE;
      last_grant_q  <= 1'b1;
      grant_q       <= 1'b0;
      txn_write_q   <= 1'b0;
      wait_cnt_q    <= '0;
      ack0_q        <= 1'b0;
      ack1_q        <= 1'b0;
      err0_q        <= 1'b0;
      err1_q        <= 1'b0;
      rdata0_q      <= '0;
      rdata1_q      <= '0;
      write_readf_q <= 1'b0;
      address_q     <= '0;
      write_data_q  <= '0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      last_grant_q  <= last_grant_d;
      grant_q       <= grant_d;
      txn_write_q   <= txn_write_d;
      wait_cnt_q    <= wait_cnt_d;
      ack0_q        <= ack0_d;
      ack1_q        <= ack1_d;
      err0_q        <= err0_d;
      err1_q        <= err1_d;
      rdata0_q      <= rdata0_d;
      rdata1_q      <= rdata1_d;
      write_readf_q <= write_readf_d;
      address_q     <= address_d;
      write_data_q  <= write_data_d;
      busy_q        <= busy_d;
    end
  end

  assign rq0_ack       = ack0_q;
  assign rq0_err       = err0_q;
  assign rq0_read_data = rdata0_q;
  assign rq1_ack       = ack1_q;
  assign rq1_err       = err1_q;
  assign rq1_read_data = rdata1_q;
  assign clock_ctrl    = clock;
  assign reset_ctrl    = reset;
  assign write_readf   = write_readf_q;
  assign address       = address_q;
  assign write_data    = write_data_q;
  assign busy          = busy_q;

endmodule

// File: tb/tb_neopixel_bus_arbiter.sv
// Bench for neopixel_bus_arbiter: directed scenarios plus randomized two-requester
// traffic checked against a transaction-level schedule model.
module tb_neopixel_bus_arbiter;

  localparam int unsigned NPIX = 12;
  localparam int unsigned LAT  = 3;
  localparam int MAXC = 1024;
  localparam int WIN  = 16;

  typedef struct packed {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] data;
  } txn_t;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        ram_init = 1'b1;
  logic        rq0_req = 1'b0, rq0_write_readf = 1'b0;
  logic [31:0] rq0_address = '0, rq0_write_data = '0;
  logic        rq1_req = 1'b0, rq1_write_readf = 1'b0;
  logic [31:0] rq1_address = '0, rq1_write_data = '0;
  logic        rq0_ack, rq0_err, rq1_ack, rq1_err;
  logic [31:0] rq0_read_data, rq1_read_data;
  logic        clock_ctrl, reset_ctrl, write_readf, busy;
  logic [31:0] address, write_data, read_data;

  int checks = 0;
  int errors = 0;

  neopixel_bus_arbiter #(.C_PIXELS(NPIX), .C_READ_LATENCY(LAT)) dut (
    .clock(clock), .reset(reset),
    .rq0_req(rq0_req), .rq0_write_readf(rq0_write_readf), .rq0_address(rq0_address),
    .rq0_write_data(rq0_write_data), .rq0_ack(rq0_ack), .rq0_err(rq0_err),
    .rq0_read_data(rq0_read_data),
    .rq1_req(rq1_req), .rq1_write_readf(rq1_write_readf), .rq1_address(rq1_address),
    .rq1_write_data(rq1_write_data), .rq1_ack(rq1_ack), .rq1_err(rq1_err),
    .rq1_read_data(rq1_read_data),
    .clock_ctrl(clock_ctrl), .reset_ctrl(reset_ctrl), .write_readf(write_readf),
    .address(address), .write_data(write_data), .read_data(read_data), .busy(busy)
  );

  always #5 clock = ~clock;

  // Downstream pixel RAM: read data appears LAT-1 cycles after the address changes.
  logic [31:0] pix [NPIX];
  logic [31:0] addr_p1 = '0;
  logic [31:0] addr_p2 = '0;
  always @(posedge clock) begin
    addr_p1 <= address;
    addr_p2 <= addr_p1;
    if (ram_init) begin
      for (int i = 0; i < NPIX; i++) pix[i] <= 32'h00A0_0000 + 32'(i);
    end else if (write_readf && address < NPIX) begin
      pix[address[3:0]] <= write_data;
    end
  end
  assign read_data = (addr_p2 < NPIX) ? pix[addr_p2[3:0]] : 32'hDEAD_BEEF;

  logic        o_ack0 [WIN], o_ack1 [WIN], o_err0 [WIN], o_err1 [WIN], o_wr [WIN], o_busy [WIN];
  logic [31:0] o_addr [WIN], o_wdata [WIN], o_rd0 [WIN], o_rd1 [WIN];
  int n_ack0, at_ack0, n_ack1, at_ack1, n_wr, at_wr;
  logic [31:0] or_rd0, or_rd1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_reqs();
    rq0_req = 1'b0;
    rq1_req = 1'b0;
  endtask

  task automatic drive(input int r, input logic wr, input logic [31:0] a, input logic [31:0] d);
    if (r == 0) begin
      rq0_req = 1'b1; rq0_write_readf = wr; rq0_address = a; rq0_write_data = d;
    end else begin
      rq1_req = 1'b1; rq1_write_readf = wr; rq1_address = a; rq1_write_data = d;
    end
  endtask

  // Records n cycles (k=0 is the current cycle); a requester lets go once it sees its ack.
  task automatic capture(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clock);
      o_ack0[k] = rq0_ack; o_ack1[k] = rq1_ack; o_err0[k] = rq0_err; o_err1[k] = rq1_err;
      o_wr[k] = write_readf; o_addr[k] = address; o_wdata[k] = write_data;
      o_rd0[k] = rq0_read_data; o_rd1[k] = rq1_read_data; o_busy[k] = busy;
      if (rq0_ack) rq0_req = 1'b0;
      if (rq1_ack) rq1_req = 1'b0;
    end
  endtask

  task automatic tally(input int n);
    n_ack0 = 0; at_ack0 = -1; n_ack1 = 0; at_ack1 = -1; n_wr = 0; at_wr = -1;
    or_rd0 = '0; or_rd1 = '0;
    for (int k = 0; k < n; k++) begin
      if (o_ack0[k]) begin if (n_ack0 == 0) at_ack0 = k; n_ack0++; end
      if (o_ack1[k]) begin if (n_ack1 == 0) at_ack1 = k; n_ack1++; end
      if (o_wr[k])   begin if (n_wr == 0)   at_wr = k;   n_wr++;   end
      or_rd0 = or_rd0 | o_rd0[k];
      or_rd1 = or_rd1 | o_rd1[k];
    end
  endtask

  function automatic logic [31:0] rand_addr(input bit allow_bad);
    int unsigned r;
    r = $urandom_range(0, 19);
    if (!allow_bad || r < 16) return 32'($urandom_range(0, NPIX - 1));
    else if (r == 16) return 32'(NPIX);
    else if (r == 17) return 32'hFFFF_FFFF;
    else return $urandom | 32'h8000_0000;
  endfunction

  // Both requesters present back-to-back queues; the expected per-cycle trace comes
  // from grant order and fixed per-kind durations counted from each IDLE cycle.
  task automatic random_phase(input string tag, input int n, input bit mixed);
    txn_t        q0[$], q1[$], tx;
    logic [31:0] ref_mem [NPIX];
    bit          e_ack0 [MAXC], e_ack1 [MAXC], e_err0 [MAXC], e_err1 [MAXC];
    bit          e_wr [MAXC], e_busy [MAXC];
    logic [31:0] e_addr [MAXC], e_wdata [MAXC], e_rd0 [MAXC], e_rd1 [MAXC];
    int t, i0, i1, lat, total, d0, d1;
    bit lg, g, bad;
    logic [31:0] rd;

    for (int i = 0; i < n; i++) begin
      tx.wr = mixed ? 1'($urandom_range(0, 1)) : 1'b1;
      tx.addr = rand_addr(mixed); tx.data = $urandom; q0.push_back(tx);
      tx.wr = mixed ? 1'($urandom_range(0, 1)) : 1'b1;
      tx.addr = rand_addr(mixed); tx.data = $urandom; q1.push_back(tx);
    end
    for (int i = 0; i < NPIX; i++) ref_mem[i] = 32'h00A0_0000 + 32'(i);
    for (int c = 0; c < MAXC; c++) begin
      e_ack0[c] = 0; e_ack1[c] = 0; e_err0[c] = 0; e_err1[c] = 0; e_wr[c] = 0; e_busy[c] = 0;
      e_addr[c] = '0; e_wdata[c] = '0; e_rd0[c] = '0; e_rd1[c] = '0;
    end

    t = 0; i0 = 0; i1 = 0; lg = 1'b1;
    while (i0 < n || i1 < n) begin
      g = (i0 < n && i1 < n) ? ~lg : (i1 < n);
      if (g) begin tx = q1[i1]; i1++; end else begin tx = q0[i0]; i0++; end
      lg = g;
      bad = (tx.addr >= NPIX);
      lat = bad ? 1 : (tx.wr ? 2 : 1 + LAT);
      for (int k = 1; k <= lat; k++) e_busy[t + k] = 1;
      rd = '0;
      if (!bad && tx.wr) begin
        e_wr[t + 1] = 1; e_addr[t + 1] = tx.addr; e_wdata[t + 1] = tx.data;
        ref_mem[tx.addr[3:0]] = tx.data;
      end else if (!bad) begin
        rd = ref_mem[tx.addr[3:0]];
      end
      if (g) begin e_ack1[t + lat] = 1; e_err1[t + lat] = bad; e_rd1[t + lat] = rd; end
      else   begin e_ack0[t + lat] = 1; e_err0[t + lat] = bad; e_rd0[t + lat] = rd; end
      t += lat + 1;
    end
    total = t + 1;

    idle_reqs(); reset = 1'b1; ram_init = 1'b1;
    tick(); tick();
    reset = 1'b0; ram_init = 1'b0;
    d0 = 0; d1 = 0;
    drive(0, q0[0].wr, q0[0].addr, q0[0].data);
    drive(1, q1[0].wr, q1[0].addr, q1[0].data);
    for (int c = 0; c < total; c++) begin
      @(negedge clock);
      check($sformatf("%s c%0d ack0", tag, c), rq0_ack, e_ack0[c]);
      check($sformatf("%s c%0d ack1", tag, c), rq1_ack, e_ack1[c]);
      check($sformatf("%s c%0d rd0", tag, c), rq0_read_data, e_rd0[c]);
      check($sformatf("%s c%0d rd1", tag, c), rq1_read_data, e_rd1[c]);
      check($sformatf("%s c%0d strobe", tag, c), write_readf, e_wr[c]);
      check($sformatf("%s c%0d busy", tag, c), busy, e_busy[c]);
      if (e_ack0[c]) check($sformatf("%s c%0d err0", tag, c), rq0_err, e_err0[c]);
      if (e_ack1[c]) check($sformatf("%s c%0d err1", tag, c), rq1_err, e_err1[c]);
      if (e_wr[c]) begin
        check($sformatf("%s c%0d addr", tag, c), address, e_addr[c]);
        check($sformatf("%s c%0d wdata", tag, c), write_data, e_wdata[c]);
      end
      if (rq0_ack) begin
        d0++;
        if (d0 < n) drive(0, q0[d0].wr, q0[d0].addr, q0[d0].data); else rq0_req = 1'b0;
      end
      if (rq1_ack) begin
        d1++;
        if (d1 < n) drive(1, q1[d1].wr, q1[d1].addr, q1[d1].data); else rq1_req = 1'b0;
      end
    end
    check({tag, " drained0"}, d0, n);
    check({tag, " drained1"}, d1, n);
    idle_reqs();
    tick();
  endtask

  initial begin
    repeat (3) @(posedge clock);
    @(negedge clock);
    check("rst reset_ctrl", reset_ctrl, 1);
    check("rst busy", busy, 0);
    check("rst acks", {rq0_ack, rq1_ack, rq0_err, rq1_err}, 0);
    check("rst strobe", write_readf, 0);
    check("rst address", address, 0);
    check("rst wdata", write_data, 0);
    check("rst rd", rq0_read_data | rq1_read_data, 0);
    reset = 1'b0; ram_init = 1'b0;
    tick();
    check("clock_ctrl", clock_ctrl, 1);
    check("reset_ctrl low", reset_ctrl, 0);

    // setup: pixel 11 gets the value read back later
    drive(0, 1'b1, 32'd11, 32'h00AB_CDEF);
    capture(4); tally(4);
    check("setup ack0 cycle", at_ack0, 2);
    check("setup strobe addr", o_addr[1], 11);

    tick();
    drive(0, 1'b1, 32'd3, 32'h0004_0201);
    capture(5); tally(5);
    check("w strobe count", n_wr, 1);
    check("w strobe cycle", at_wr, 1);
    check("w address", o_addr[1], 3);
    check("w data", o_wdata[1], 32'h0004_0201);
    check("w ack0 count", n_ack0, 1);
    check("w ack0 cycle", at_ack0, 2);
    check("w err0", o_err0[2], 0);
    check("w ack1 count", n_ack1, 0);
    check("w busy c0", o_busy[0], 0);
    check("w busy c1", o_busy[1], 1);
    check("w busy c3", o_busy[3], 0);
    check("w ram", pix[3], 32'h0004_0201);

    tick();
    drive(1, 1'b0, 32'd11, 32'hFFFF_FFFF);
    capture(7); tally(7);
    check("r ack1 count", n_ack1, 1);
    check("r ack1 cycle", at_ack1, 1 + LAT);
    check("r data", o_rd1[1 + LAT], 32'h00AB_CDEF);
    check("r err1", o_err1[1 + LAT], 0);
    check("r data after ack", o_rd1[2 + LAT], 0);
    check("r no strobe", n_wr, 0);
    check("r address held", o_addr[LAT], 11);
    check("r other side", {31'b0, n_ack0 != 0} | or_rd0, 0);

    tick();
    drive(0, 1'b1, 32'd12, 32'h0012_3456);
    capture(4); tally(4);
    check("e12 ack0 cycle", at_ack0, 1);
    check("e12 ack0 count", n_ack0, 1);
    check("e12 err0", o_err0[1], 1);
    check("e12 rd0", o_rd0[1], 0);
    check("e12 no strobe", n_wr, 0);
    check("e12 busy c2", o_busy[2], 0);

    tick();
    drive(1, 1'b0, 32'hFFFF_FFFF, 32'h0);
    capture(4); tally(4);
    check("eFF ack1 cycle", at_ack1, 1);
    check("eFF err1", o_err1[1], 1);
    check("eFF rd1", or_rd1, 0);
    check("eFF no strobe", n_wr, 0);

    // rq0 withdraws its request while its write is being issued
    tick();
    drive(0, 1'b1, 32'd5, 32'h55);
    @(negedge clock);
    tick();
    rq0_req = 1'b0;
    drive(1, 1'b1, 32'd6, 32'h66);
    capture(7); tally(7);
    check("drop strobe k0", o_wr[0], 1);
    check("drop addr k0", o_addr[0], 5);
    check("drop ack0 count", n_ack0, 1);
    check("drop ack0 cycle", at_ack0, 1);
    check("drop idle k2", o_busy[2], 0);
    check("drop rq1 strobe", o_wr[3], 1);
    check("drop rq1 addr", o_addr[3], 6);
    check("drop rq1 data", o_wdata[3], 32'h66);
    check("drop ack1 cycle", at_ack1, 4);
    check("drop strobe count", n_wr, 2);

    // reset while rq0's read sits in WAIT
    tick();
    drive(0, 1'b0, 32'd7, 32'h0);
    @(negedge clock);
    tick();
    tick();
    reset = 1'b1; rq0_req = 1'b0;
    tick();
    reset = 1'b0;
    @(negedge clock);
    check("mid-rst busy", busy, 0);
    check("mid-rst ack", {rq0_ack, rq1_ack}, 0);
    check("mid-rst address", address, 0);
    check("mid-rst wdata", write_data, 0);
    check("mid-rst strobe", write_readf, 0);
    check("mid-rst rd0", rq0_read_data, 0);
    capture(4); tally(4);
    check("mid-rst no late ack", n_ack0 + n_ack1, 0);
    tick();
    drive(0, 1'b1, 32'd1, 32'hA1);
    drive(1, 1'b1, 32'd2, 32'hB2);
    capture(8); tally(8);
    check("tie first addr", o_addr[1], 1);
    check("tie ack0 cycle", at_ack0, 2);
    check("tie second addr", o_addr[4], 2);
    check("tie ack1 cycle", at_ack1, 5);

    tick();
    random_phase("wr", 50, 1'b0);
    random_phase("mix", 40, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
